// File: rtl/sm83_pkg.sv
// Shared SM83 bus definitions.
// Holds the memory responder FSM states, the memory region type, the fixed
// address map constants and the address decode function. The decode lives
// here so the core-side bus model and the responder agree on one map.
package sm83_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } mem_rsp_state_t;

   // Echo space decodes to REG_WRAM; the WRAM index is addr[12:0] either way.
   typedef enum logic [1:0] {
      REG_ROM   = 2'd0,
      REG_WRAM  = 2'd1,
      REG_HRAM  = 2'd2,
      REG_UNMAP = 2'd3
   } mem_region_t;

   localparam logic [15:0] WRAM_BASE     = 16'hC000;
   localparam logic [15:0] ECHO_BASE     = 16'hE000;
   localparam logic [15:0] ECHO_END      = 16'hFDFF;
   localparam logic [15:0] HRAM_BASE     = 16'hFF80;
   localparam logic [15:0] HRAM_END      = 16'hFFFE;
   localparam logic [7:0]  UNMAPPED_DATA = 8'hFF;

   // ROM is checked first, so a large rom_aw shadows the RAM regions.
   // WRAM and its echo are contiguous (WRAM_BASE..ECHO_END), so one range
   // test covers both.
   function automatic mem_region_t mem_decode(input logic [15:0] addr,
                                              input int rom_aw);
      mem_region_t r;
      if ({16'd0, addr} < (32'd1 << rom_aw)) begin
         r = REG_ROM;
      end else if (addr >= WRAM_BASE && addr <= ECHO_END) begin
         r = REG_WRAM;
      end else if (addr >= HRAM_BASE && addr <= HRAM_END) begin
         r = REG_HRAM;
      end else begin
         r = REG_UNMAP;
      end
      return r;
   endfunction

endpackage

// File: rtl/sm83_mem_responder_if.sv
// Core-to-memory request/response bus.
//   req_valid/req_ready/req_we/req_addr/req_wdata : request channel
//   rsp_valid/rsp_rdata                           : response channel
//   busy                                          : request in flight
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both 1; the master holds req_we/req_addr/req_wdata stable
// while req_valid is high and not yet accepted. rsp_valid is a one-cycle
// pulse with no ready: the master must take the response that cycle.
interface sm83_mem_responder_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [15:0] req_addr;
   logic [7:0]  req_wdata;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        busy;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, busy
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, busy
   );

endinterface

// File: rtl/sm83_sp_ram.sv
// Synchronous single-port byte RAM, read-first.
//   clk   : clock
//   en    : access enable
//   we    : write enable (qualified by en)
//   addr  : word address
//   wdata : write data
//   rdata : registered read data (old contents on a write cycle)
// Contents are never reset.
module sm83_sp_ram #(
   parameter int AW    = 8,
   parameter int DEPTH = 2 ** AW
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[addr] <= wdata;
         end
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/sm83_mem_responder.sv
// Memory-side responder for the SM83 core bus.
// Takes one byte read or write per request, decodes ROM/WRAM/echo/HRAM/
// unmapped, inserts per-region wait states and returns a one-cycle response.
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus          : request/response bus (slave side)
//   ld_en        : ROM preload strobe, honoured in IDLE only, beats requests
//   ld_addr      : preload address (low ROM_AW bits used)
//   ld_data      : preload data
//   rom_wr_err   : sticky flag, a core write targeted ROM
//   dbg_state    : current FSM state
module sm83_mem_responder
   import sm83_pkg::*;
#(
   parameter int ROM_AW   = 15,
   parameter int ROM_WAIT = 1,
   parameter int RAM_WAIT = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   sm83_mem_responder_if.slave  bus,
   input  logic                 ld_en,
   input  logic [15:0]          ld_addr,
   input  logic [7:0]           ld_data,
   output logic                 rom_wr_err,
   output mem_rsp_state_t       dbg_state
);

   // The wait counter is 4 bits wide; anything outside 0..15 cannot be honoured.
   if (ROM_WAIT < 0 || ROM_WAIT > 15) begin : g_bad_rom_wait
      $error("sm83_mem_responder: ROM_WAIT must be in 0..15");
   end
   if (RAM_WAIT < 0 || RAM_WAIT > 15) begin : g_bad_ram_wait
      $error("sm83_mem_responder: RAM_WAIT must be in 0..15");
   end
   if (ROM_AW < 1 || ROM_AW > 16) begin : g_bad_rom_aw
      $error("sm83_mem_responder: ROM_AW must be in 1..16");
   end

   localparam logic [3:0] ROM_WAIT_C = 4'(ROM_WAIT);
   localparam logic [3:0] RAM_WAIT_C = 4'(RAM_WAIT);

   mem_rsp_state_t state_q, state_d;
   logic [3:0]     cnt_q;
   logic [15:0]    addr_q;
   logic           we_q;
   logic [7:0]     wdata_q;
   logic [7:0]     rdata_q;

   logic           accept;
   logic           issue;
   logic           preload;
   logic [3:0]     req_wait;

   logic [15:0]    acc_addr;
   logic           acc_we;
   logic [7:0]     acc_wdata;
   mem_region_t    acc_region;
   mem_region_t    rsp_region;

   logic           rom_en, wram_en, hram_en;
   logic [ROM_AW-1:0] rom_addr;
   logic [7:0]     rom_rdata, wram_rdata, hram_rdata;
   logic [7:0]     rsp_mux;
   logic           unused_ld_hi;

   // Zero-wait requests access memory on the accept edge itself, so the
   // access uses the live request in IDLE and the latched copy afterwards.
   assign acc_addr   = (state_q == IDLE) ? bus.req_addr  : addr_q;
   assign acc_we     = (state_q == IDLE) ? bus.req_we    : we_q;
   assign acc_wdata  = (state_q == IDLE) ? bus.req_wdata : wdata_q;
   assign acc_region = mem_decode(acc_addr, ROM_AW);
   assign rsp_region = mem_decode(addr_q, ROM_AW);
   assign req_wait   = (acc_region == REG_ROM) ? ROM_WAIT_C : RAM_WAIT_C;
   assign preload    = (state_q == IDLE) && ld_en;

   always_comb begin
      state_d       = state_q;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      accept        = 1'b0;
      issue         = 1'b0;
      unique case (state_q)
         IDLE: begin
            bus.req_ready = !ld_en;
            if (bus.req_valid && !ld_en) begin
               accept = 1'b1;
               if (req_wait == 4'd0) begin
                  issue   = 1'b1;
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd1) begin
               issue   = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            bus.rsp_valid = 1'b1;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= 4'd0;
         addr_q  <= 16'd0;
         we_q    <= 1'b0;
         wdata_q <= 8'd0;
      end else if (accept) begin
         cnt_q   <= req_wait;
         addr_q  <= bus.req_addr;
         we_q    <= bus.req_we;
         wdata_q <= bus.req_wdata;
      end else if (state_q == WAIT) begin
         cnt_q <= cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_wr_err <= 1'b0;
      end else if (issue && acc_we && acc_region == REG_ROM) begin
         rom_wr_err <= 1'b1;
      end
   end

   // ROM takes preload writes; core writes to ROM only raise the error flag.
   assign rom_en   = preload || (issue && !acc_we && acc_region == REG_ROM);
   assign rom_addr = preload ? ld_addr[ROM_AW-1:0] : acc_addr[ROM_AW-1:0];
   assign wram_en  = issue && (acc_region == REG_WRAM);
   assign hram_en  = issue && (acc_region == REG_HRAM);
   assign unused_ld_hi = ^(ld_addr >> ROM_AW);

   sm83_sp_ram #(.AW(ROM_AW), .DEPTH(2 ** ROM_AW)) u_rom (
      .clk   (clk),
      .en    (rom_en),
      .we    (preload),
      .addr  (rom_addr),
      .wdata (ld_data),
      .rdata (rom_rdata)
   );

   sm83_sp_ram #(.AW(13), .DEPTH(8192)) u_wram (
      .clk   (clk),
      .en    (wram_en),
      .we    (acc_we),
      .addr  (acc_addr[12:0]),
      .wdata (acc_wdata),
      .rdata (wram_rdata)
   );

   sm83_sp_ram #(.AW(7), .DEPTH(127)) u_hram (
      .clk   (clk),
      .en    (hram_en),
      .we    (acc_we),
      .addr  (acc_addr[6:0]),
      .wdata (acc_wdata),
      .rdata (hram_rdata)
   );

   // In RESP the memory output registers hold this request's data; outside
   // RESP the last response value is held in rdata_q.
   always_comb begin
      rsp_mux = rdata_q;
      if (state_q == RESP) begin
         if (we_q) begin
            rsp_mux = 8'h00;
         end else begin
            unique case (rsp_region)
               REG_ROM:  rsp_mux = rom_rdata;
               REG_WRAM: rsp_mux = wram_rdata;
               REG_HRAM: rsp_mux = hram_rdata;
               default:  rsp_mux = UNMAPPED_DATA;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= 8'h00;
      end else if (state_q == RESP) begin
         rdata_q <= rsp_mux;
      end
   end

   assign bus.rsp_rdata = rsp_mux;
   assign bus.busy      = (state_q != IDLE);
   assign dbg_state     = state_q;

endmodule
